// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pkg : shared opcodes, ALU-op/select encodings and FSM states  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Also consumed by aluControl; 2'b11 is reserved and never driven.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | main_control_fsm : multicycle Small-MIPS main controller           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module main_control_fsm
  import mips_pkg::*;
#(
  parameter int INSTR_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [5:0]             i_opcode,
  input  logic                   i_zero,
  input  logic                   i_memReady,
  output logic                   o_pcWrite,
  output logic                   o_pcWriteCond,
  output logic                   o_iorD,
  output logic                   o_memRead,
  output logic                   o_memWrite,
  output logic                   o_irWrite,
  output logic                   o_regDst,
  output logic                   o_memToReg,
  output logic                   o_regWrite,
  output logic                   o_aluSrcA,
  output logic [1:0]             o_aluSrcB,
  output logic [1:0]             o_aluOp,
  output logic [1:0]             o_pcSource,
  output logic                   o_illegal,
  output logic [3:0]             o_state,
  output logic [INSTR_CNT_W-1:0] o_instrCount
);

  state_e                 state_q, state_d;
  logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
  logic                   retire;

  // The zero flag gates the PC load in the datapath, not here.
  logic unused_zero;
  assign unused_zero = i_zero;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (i_memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (i_opcode == OP_LW)      state_d = S_MEMRD;
        else if (i_opcode == OP_SW) state_d = S_MEMWR;
        else                        state_d = S_FETCH;
      end
      S_MEMRD:  if (i_memReady) state_d = S_MEMWB;
      S_MEMWR: begin
        if (i_memReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + INSTR_CNT_W'(1) : cnt_q;
  end

  always_comb begin
    o_pcWrite     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_iorD        = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_irWrite     = 1'b0;
    o_regDst      = 1'b0;
    o_memToReg    = 1'b0;
    o_regWrite    = 1'b0;
    o_aluSrcA     = 1'b0;
    o_aluSrcB     = SRCB_B;
    o_aluOp       = ALUOP_ADD;
    o_pcSource    = PCSRC_ALU;
    o_illegal     = 1'b0;
    o_state       = state_q;
    case (state_q)
      S_FETCH: begin
        o_memRead = 1'b1;
        o_aluSrcB = SRCB_FOUR;
        o_irWrite = i_memReady;
        o_pcWrite = i_memReady;
      end
      S_DECODE: begin
        o_aluSrcB = SRCB_IMM_SH;
        o_illegal = ~is_supported(i_opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        o_memRead = 1'b1;
        o_iorD    = 1'b1;
      end
      S_MEMWB: begin
        o_regWrite = 1'b1;
        o_memToReg = 1'b1;
      end
      S_MEMWR: begin
        o_memWrite = 1'b1;
        o_iorD     = 1'b1;
      end
      S_EXEC: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_regWrite = 1'b1;
        o_regDst   = 1'b1;
      end
      S_BRANCH: begin
        o_aluSrcA     = 1'b1;
        o_aluOp       = ALUOP_SUB;
        o_pcWriteCond = 1'b1;
        o_pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_pcWrite  = 1'b1;
        o_pcSource = PCSRC_JUMP;
      end
      S_ADDIWB:  o_regWrite = 1'b1;
      default: ;
    endcase
    // Reset overrides everything so an in-flight access is abandoned with no strobe.
    if (i_rst) begin
      o_pcWrite     = 1'b0;
      o_pcWriteCond = 1'b0;
      o_iorD        = 1'b0;
      o_memRead     = 1'b0;
      o_memWrite    = 1'b0;
      o_irWrite     = 1'b0;
      o_regDst      = 1'b0;
      o_memToReg    = 1'b0;
      o_regWrite    = 1'b0;
      o_aluSrcA     = 1'b0;
      o_aluSrcB     = SRCB_B;
      o_aluOp       = ALUOP_ADD;
      o_pcSource    = PCSRC_ALU;
      o_illegal     = 1'b0;
      o_state       = 4'd0;
    end
  end

  assign o_instrCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_main_control_fsm : directed scoreboard bench for the controller |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_main_control_fsm;

  // Control word order:
  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,regDst,memToReg,
  //  regWrite,aluSrcA,aluSrcB[1:0],aluOp[1:0],pcSource[1:0],illegal}
  localparam logic [16:0] c_RESET      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] c_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] c_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] c_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] c_DECODE_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] c_MEMADR     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] c_MEMRD      = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] c_MEMWB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] c_MEMWR      = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] c_EXEC       = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] c_ALUWB      = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] c_BRANCH     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] c_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] c_ADDIEX     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] c_ADDIWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] c_R = 6'b000000, c_LW = 6'b100011, c_SW = 6'b101011;
  localparam logic [5:0] c_BEQ = 6'b000100, c_J = 6'b000010, c_ADDI = 6'b001000;
  localparam logic [5:0] c_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [15:0] instr_count;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  main_control_fsm #(.INSTR_CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero),
    .i_memReady(mem_ready),
    .o_pcWrite(pc_write), .o_pcWriteCond(pc_write_cond), .o_iorD(iord),
    .o_memRead(mem_read), .o_memWrite(mem_write), .o_irWrite(ir_write),
    .o_regDst(reg_dst), .o_memToReg(mem_to_reg), .o_regWrite(reg_write),
    .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b), .o_aluOp(alu_op),
    .o_pcSource(pc_source), .o_illegal(illegal), .o_state(state),
    .o_instrCount(instr_count)
  );

  // Monitor: every cycle is an output beat; compare mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [16:0] ctl;
      e   = exp_q.pop_front();
      ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal};
      checks = checks + 3;
      if (state !== e.st) begin
        errors = errors + 1;
        $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
      end
      if (ctl !== e.ctl) begin
        errors = errors + 1;
        $display("FAIL %s ctrl: got %b expected %b", e.tag, ctl, e.ctl);
      end
      if (instr_count !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL %s count: got %h expected %h", e.tag, instr_count, e.cnt);
      end
    end
  end

  task automatic step(input string tag, input logic r, input logic rdy,
                      input logic z, input logic [5:0] op, input logic [3:0] st,
                      input logic [16:0] ctl, input logic [15:0] cnt);
    exp_t e;
    rst = r; mem_ready = rdy; zero = z; opcode = op;
    e.tag = tag; e.st = st; e.ctl = ctl; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = c_R;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1, 1, 0, c_LW, 4'd0, c_RESET, 16'h0000);

    // lw, zero-wait memory
    step("lw_fetch",  0, 1, 0, c_LW, 4'd0, c_FETCH_RDY, 16'h0000);
    step("lw_decode", 0, 1, 0, c_LW, 4'd1, c_DECODE,    16'h0000);
    step("lw_memadr", 0, 1, 0, c_LW, 4'd2, c_MEMADR,    16'h0000);
    step("lw_memrd",  0, 1, 0, c_LW, 4'd3, c_MEMRD,     16'h0000);
    step("lw_memwb",  0, 1, 0, c_LW, 4'd4, c_MEMWB,     16'h0000);

    // R-type with three stalled fetch cycles
    for (int i = 0; i < 3; i++)
      step("r_fetch_wait", 0, 0, 0, c_R, 4'd0, c_FETCH_WAIT, 16'h0001);
    step("r_fetch",  0, 1, 0, c_R, 4'd0, c_FETCH_RDY, 16'h0001);
    step("r_decode", 0, 0, 0, c_R, 4'd1, c_DECODE,    16'h0001);
    step("r_exec",   0, 0, 0, c_R, 4'd6, c_EXEC,      16'h0001);
    step("r_aluwb",  0, 0, 0, c_R, 4'd7, c_ALUWB,     16'h0001);

    // beq, not taken then taken
    step("beq0_fetch",  0, 1, 0, c_BEQ, 4'd0, c_FETCH_RDY, 16'h0002);
    step("beq0_decode", 0, 1, 0, c_BEQ, 4'd1, c_DECODE,    16'h0002);
    step("beq0_branch", 0, 1, 0, c_BEQ, 4'd8, c_BRANCH,    16'h0002);
    step("beq1_fetch",  0, 1, 1, c_BEQ, 4'd0, c_FETCH_RDY, 16'h0003);
    step("beq1_decode", 0, 1, 1, c_BEQ, 4'd1, c_DECODE,    16'h0003);
    step("beq1_branch", 0, 1, 1, c_BEQ, 4'd8, c_BRANCH,    16'h0003);

    // sw with two wait cycles
    step("sw_fetch",  0, 1, 0, c_SW, 4'd0, c_FETCH_RDY, 16'h0004);
    step("sw_decode", 0, 1, 0, c_SW, 4'd1, c_DECODE,    16'h0004);
    step("sw_memadr", 0, 1, 0, c_SW, 4'd2, c_MEMADR,    16'h0004);
    step("sw_wait1",  0, 0, 0, c_SW, 4'd5, c_MEMWR,     16'h0004);
    step("sw_wait2",  0, 0, 0, c_SW, 4'd5, c_MEMWR,     16'h0004);
    step("sw_done",   0, 1, 0, c_SW, 4'd5, c_MEMWR,     16'h0004);

    // unsupported opcode
    step("ill_fetch",  0, 1, 0, c_BAD, 4'd0, c_FETCH_RDY,  16'h0005);
    step("ill_decode", 0, 1, 0, c_BAD, 4'd1, c_DECODE_ILL, 16'h0005);

    // addi
    step("addi_fetch",  0, 1, 0, c_ADDI, 4'd0,  c_FETCH_RDY, 16'h0005);
    step("addi_decode", 0, 1, 0, c_ADDI, 4'd1,  c_DECODE,    16'h0005);
    step("addi_ex",     0, 1, 0, c_ADDI, 4'd10, c_ADDIEX,    16'h0005);
    step("addi_wb",     0, 1, 0, c_ADDI, 4'd11, c_ADDIWB,    16'h0005);

    // reset during a stalled store
    step("rsw_fetch",  0, 1, 0, c_SW, 4'd0, c_FETCH_RDY, 16'h0006);
    step("rsw_decode", 0, 1, 0, c_SW, 4'd1, c_DECODE,    16'h0006);
    step("rsw_memadr", 0, 1, 0, c_SW, 4'd2, c_MEMADR,    16'h0006);
    step("rsw_wait",   0, 0, 0, c_SW, 4'd5, c_MEMWR,     16'h0006);
    step("rsw_reset",  1, 0, 0, c_SW, 4'd0, c_RESET,     16'h0006);
    step("rsw_after",  0, 0, 0, c_SW, 4'd0, c_FETCH_WAIT, 16'h0000);

    // counter wrap on j
    force dut.cnt_q = 16'hFFFF;
    step("j_fetch",  0, 1, 0, c_J, 4'd0, c_FETCH_RDY, 16'hFFFF);
    release dut.cnt_q;
    step("j_decode", 0, 1, 0, c_J, 4'd1, c_DECODE, 16'hFFFF);
    step("j_jump",   0, 1, 0, c_J, 4'd9, c_JUMP,   16'hFFFF);
    step("j_wrap",   0, 0, 0, c_J, 4'd0, c_FETCH_WAIT, 16'h0000);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      checks = checks + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
